// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the 5-stage core: load-use, branch redirect,
// I/D memory busy and HLT drain. Drives PC and pipeline-register enables.
module hazard_stall_ctrl #(
    parameter int REG_W   = 4,
    parameter int DRAIN_N = 3,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] IFID_rs_i,
    input  logic [REG_W-1:0] IFID_rt_i,
    input  logic             IFID_uses_rt_i,
    input  logic             IFID_hlt_i,
    input  logic [REG_W-1:0] IDEX_rt_i,
    input  logic             IDEX_MemRead_i,
    input  logic             branch_taken_i,
    input  logic             IF_busy_i,
    input  logic             MEM_busy_i,
    output logic             PC_write_o,
    output logic             IFID_write_o,
    output logic             IFID_flush_o,
    output logic             IDEX_bubble_o,
    output logic             pipe_freeze_o,
    output logic             MEMWB_bubble_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] stall_cycles_o
);

    localparam int DCW = (DRAIN_N > 1) ? $clog2(DRAIN_N) : 1;
    localparam logic [DCW-1:0]   DRAIN_INIT = DCW'(DRAIN_N - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [DCW-1:0]   drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             load_use;

    // Register 0 is hard-wired, so a load targeting it never creates a hazard.
    assign load_use = IDEX_MemRead_i && (IDEX_rt_i != '0) &&
                      ((IDEX_rt_i == IFID_rs_i) ||
                       (IFID_uses_rt_i && (IDEX_rt_i == IFID_rt_i)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            drain_cnt_q <= '0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            stall_q     <= stall_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        drain_cnt_d    = drain_cnt_q;
        PC_write_o     = 1'b1;
        IFID_write_o   = 1'b1;
        IFID_flush_o   = 1'b0;
        IDEX_bubble_o  = 1'b0;
        pipe_freeze_o  = 1'b0;
        MEMWB_bubble_o = 1'b0;
        halted_o       = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (MEM_busy_i) begin
                    pipe_freeze_o  = 1'b1;
                    MEMWB_bubble_o = 1'b1;
                    PC_write_o     = 1'b0;
                    IFID_write_o   = 1'b0;
                end else if (load_use) begin
                    PC_write_o    = 1'b0;
                    IFID_write_o  = 1'b0;
                    IDEX_bubble_o = 1'b1;
                end else if (branch_taken_i && IF_busy_i) begin
                    PC_write_o    = 1'b0;
                    IFID_write_o  = 1'b0;
                    IDEX_bubble_o = 1'b1;
                end else if (branch_taken_i) begin
                    IFID_flush_o = 1'b1;
                end else if (IF_busy_i) begin
                    PC_write_o   = 1'b0;
                    IFID_flush_o = 1'b1;
                end else if (IFID_hlt_i) begin
                    PC_write_o   = 1'b0;
                    IFID_write_o = 1'b0;
                    state_d      = ST_DRAIN;
                    drain_cnt_d  = DRAIN_INIT;
                end
            end
            ST_DRAIN: begin
                PC_write_o    = 1'b0;
                IFID_write_o  = 1'b0;
                IDEX_bubble_o = 1'b1;
                // A frozen pipe is not draining, so the countdown waits too.
                if (MEM_busy_i) begin
                    pipe_freeze_o  = 1'b1;
                    MEMWB_bubble_o = 1'b1;
                end else if (drain_cnt_q == '0) begin
                    state_d = ST_HALT;
                end else begin
                    drain_cnt_d = drain_cnt_q - DCW'(1);
                end
            end
            ST_HALT: begin
                halted_o       = 1'b1;
                PC_write_o     = 1'b0;
                IFID_write_o   = 1'b0;
                IDEX_bubble_o  = 1'b1;
                MEMWB_bubble_o = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (!rst_n) begin
            PC_write_o     = 1'b1;
            IFID_write_o   = 1'b1;
            IFID_flush_o   = 1'b0;
            IDEX_bubble_o  = 1'b0;
            pipe_freeze_o  = 1'b0;
            MEMWB_bubble_o = 1'b0;
            halted_o       = 1'b0;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (!PC_write_o && (state_q != ST_HALT) && (stall_q != CNT_MAX))
            stall_d = stall_q + CNT_W'(1);
    end

    assign stall_cycles_o = stall_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed-vector bench for hazard_stall_ctrl; expectations are queued by the
// stimulus and checked by an independent negedge monitor.
module tb_hazard_stall_ctrl;

    localparam int CW = 4;

    // expected bits: {PC_write, IFID_write, IFID_flush, IDEX_bubble, pipe_freeze, MEMWB_bubble, halted}
    localparam logic [6:0] E_DEF  = 7'b1100000;
    localparam logic [6:0] E_LU   = 7'b0001000;
    localparam logic [6:0] E_BRW  = 7'b0001000;
    localparam logic [6:0] E_BRF  = 7'b1110000;
    localparam logic [6:0] E_IFB  = 7'b0110000;
    localparam logic [6:0] E_FRZ  = 7'b0000110;
    localparam logic [6:0] E_HLT  = 7'b0000000;
    localparam logic [6:0] E_DRN  = 7'b0001000;
    localparam logic [6:0] E_DRZ  = 7'b0001110;
    localparam logic [6:0] E_HALT = 7'b0001011;

    typedef struct {
        int         id;
        logic       rst;
        logic [6:0] exp;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    rs = '0, rt = '0, xrt = '0;
    logic          urt = 1'b0, hlt = 1'b0, mr = 1'b0, br = 1'b0, ifb = 1'b0, mb = 1'b0;
    logic          pcw, ifidw, flush, bubble, freeze, mwb, halted;
    logic [CW-1:0] stall;

    exp_t          sb[$];
    logic [CW-1:0] exp_cnt = '0;
    int            total = 0;
    int            bad = 0;
    int            vec_id = 0;

    hazard_stall_ctrl #(.REG_W(4), .DRAIN_N(3), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .IFID_rs_i      (rs),
        .IFID_rt_i      (rt),
        .IFID_uses_rt_i (urt),
        .IFID_hlt_i     (hlt),
        .IDEX_rt_i      (xrt),
        .IDEX_MemRead_i (mr),
        .branch_taken_i (br),
        .IF_busy_i      (ifb),
        .MEM_busy_i     (mb),
        .PC_write_o     (pcw),
        .IFID_write_o   (ifidw),
        .IFID_flush_o   (flush),
        .IDEX_bubble_o  (bubble),
        .pipe_freeze_o  (freeze),
        .MEMWB_bubble_o (mwb),
        .halted_o       (halted),
        .stall_cycles_o (stall)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic [3:0] a_rs, input logic [3:0] a_rt,
                        input logic a_urt, input logic a_hlt, input logic [3:0] a_xrt,
                        input logic a_mr, input logic a_br, input logic a_ifb,
                        input logic a_mb, input logic [6:0] e);
        exp_t x;
        @(posedge clk);
        #1;
        rst_n = r; rs = a_rs; rt = a_rt; urt = a_urt; hlt = a_hlt;
        xrt = a_xrt; mr = a_mr; br = a_br; ifb = a_ifb; mb = a_mb;
        x.id = vec_id; x.rst = r; x.exp = e;
        vec_id++;
        sb.push_back(x);
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            logic [6:0] act;
            e = sb.pop_front();
            act = {pcw, ifidw, flush, bubble, freeze, mwb, halted};
            total++;
            if (act !== e.exp) begin
                bad++;
                $display("FAIL vec%0d outputs act=%b exp=%b", e.id, act, e.exp);
            end
            if (!e.rst) exp_cnt = '0;
            total++;
            if (stall !== exp_cnt) begin
                bad++;
                $display("FAIL vec%0d stall_cycles act=%0d exp=%0d", e.id, stall, exp_cnt);
            end
            if (e.rst && !e.exp[6] && !e.exp[0] && exp_cnt != '1)
                exp_cnt = exp_cnt + 1'b1;
        end
    end

    initial begin
        // reset with a load-use pattern on the inputs: RUN defaults must hold
        step(0, 4'd3, 4'd0, 0, 0, 4'd3, 1, 1, 1, 0, E_DEF);
        step(0, 4'd3, 4'd0, 0, 0, 4'd3, 1, 0, 0, 1, E_DEF);
        step(1, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 0, E_DEF);
        // LW R3 in EX, ADD R4,R3,R2 in ID: one bubble, then the load moves on
        step(1, 4'd3, 4'd2, 1, 0, 4'd3, 1, 0, 0, 0, E_LU);
        step(1, 4'd3, 4'd2, 1, 0, 4'd0, 0, 0, 0, 0, E_DEF);
        // LW R0 / ADD R4,R0,R2: no stall
        step(1, 4'd0, 4'd2, 1, 0, 4'd0, 1, 0, 0, 0, E_DEF);
        // LW R3 / SW R5 with rt=3 but rt not read: no stall
        step(1, 4'd5, 4'd3, 0, 0, 4'd3, 1, 0, 0, 0, E_DEF);
        // same, rt read: stall via rt path
        step(1, 4'd5, 4'd3, 1, 0, 4'd3, 1, 0, 0, 0, E_LU);
        // taken branch waiting on fetch for 2 cycles, then redirect
        step(1, 4'd1, 4'd2, 1, 0, 4'd0, 0, 1, 1, 0, E_BRW);
        step(1, 4'd1, 4'd2, 1, 0, 4'd0, 0, 1, 1, 0, E_BRW);
        step(1, 4'd1, 4'd2, 1, 0, 4'd0, 0, 1, 0, 0, E_BRF);
        // MEM_busy 4 cycles with LU and branch also high
        for (int i = 0; i < 4; i++)
            step(1, 4'd7, 4'd2, 1, 0, 4'd7, 1, 1, 1, 1, E_FRZ);
        step(1, 4'd7, 4'd2, 1, 0, 4'd7, 1, 1, 0, 0, E_LU);
        step(1, 4'd7, 4'd2, 1, 0, 4'd0, 0, 1, 0, 0, E_BRF);
        // fetch miss alone
        step(1, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 1, 0, E_IFB);
        // HLT, drain with one MEM_busy cycle; hazards in DRAIN are ignored
        step(1, 4'd0, 4'd0, 0, 1, 4'd0, 0, 0, 0, 0, E_HLT);
        step(1, 4'd4, 4'd0, 0, 0, 4'd4, 1, 1, 1, 0, E_DRN);
        step(1, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 1, E_DRZ);
        step(1, 4'd0, 4'd0, 0, 0, 4'd0, 0, 1, 0, 0, E_DRN);
        step(1, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 1, 0, E_DRN);
        step(1, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 0, E_HALT);
        step(1, 4'd4, 4'd0, 0, 0, 4'd4, 1, 1, 1, 1, E_HALT);
        step(0, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 0, E_DEF);
        step(1, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 0, E_DEF);
        // reset mid-DRAIN returns to RUN with a fresh drain
        step(1, 4'd0, 4'd0, 0, 1, 4'd0, 0, 0, 0, 0, E_HLT);
        step(1, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 0, E_DRN);
        step(0, 4'd0, 4'd0, 0, 1, 4'd0, 0, 0, 0, 0, E_DEF);
        step(1, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 0, E_DEF);
        // reset mid-freeze
        step(1, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 1, E_FRZ);
        step(0, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 1, E_DEF);
        step(1, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 0, E_DEF);
        // counter saturation: 20 fetch-miss cycles
        for (int i = 0; i < 20; i++)
            step(1, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 1, 0, E_IFB);
        step(1, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 0, E_DEF);
        step(1, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 0, E_DEF);

        for (int i = 0; i < 10 && sb.size() != 0; i++)
            @(posedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain_scoreboard left=%0d exp=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
